// File: rtl/arb_defs.sv
// Shared encodings and helpers for the unified-memory port arbiter.
package arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Counter width that can hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_priority.sv
// D-over-IF pick with a saturating run counter that forces a fetch grant
// after MAX_DATA_RUN back-to-back contested data grants.
module arb_priority #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic CLK,
  input  logic resetl,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_pick,
  output logic d_pick
);

  localparam int RW = $clog2(MAX_DATA_RUN + 1);

  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          starve;

  assign starve  = (run_cnt_q == RW'(MAX_DATA_RUN));
  assign d_pick  = arb_en & d_req & ~(if_req & starve);
  assign if_pick = arb_en & if_req & ~d_pick;

  // Only contested D grants count toward starvation; d_pick with if_req implies !starve.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (if_pick) begin
      run_cnt_d = '0;
    end else if (d_pick && if_req && !starve) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (D) ports:
// one transaction at a time, fixed read latency, response steered to the owner.
module mem_port_arbiter
  import arb_defs::*;
#(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int MEM_LAT      = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          CLK,
  input  logic          resetl,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = cnt_width(MEM_LAT);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic arb_en, if_pick, d_pick, rsp_fire;

  // Gating with resetl keeps grants low while reset is held, even though state reads IDLE.
  assign arb_en = (state_q == IDLE) & resetl;

  arb_priority #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_priority (
    .CLK    (CLK),
    .resetl (resetl),
    .arb_en (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .if_pick(if_pick),
    .d_pick (d_pick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_pick) begin
          state_d = CMD;
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (if_pick) begin
          state_d = CMD;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
        end
      end
      CMD: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign if_gnt    = if_pick;
  assign d_gnt     = d_pick;
  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == CMD);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign rsp_fire  = (state_q == WAIT) && (cnt_q == '0);
  assign if_rvalid = rsp_fire && (owner_q == OWN_IF);
  assign d_rvalid  = rsp_fire && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule
